// File: rtl/instr_fetcher_pkg.sv
// Shared types for the instruction fetcher: FSM state encodings, word width, address helper.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package instr_fetcher_pkg;

  localparam int INSTR_WIDTH = 32;

  typedef enum logic [2:0] {
    FETCH_IDLE     = 3'd0,
    FETCH_WAIT_MEM = 3'd1,
    FETCH_HOLD     = 3'd2,
    FETCH_WAIT_PC  = 3'd3,
    FETCH_DRAIN    = 3'd4
  } fetch_state_t;

  // Memory is word-addressed on the bus; the PC keeps its low bits untouched.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetcher_icache.sv
// Direct-mapped instruction cache, one word per line, addressed by word address [31:2].
// Latency: lookup is combinational; a fill is visible to lookups from the next cycle.
// Backpressure: none; a fill is always accepted, lookups never stall.
module instr_fetcher_icache
  import instr_fetcher_pkg::*;
#(
  parameter int INDEX_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:2]            lookup_addr,
  output logic                   hit,
  output logic [INSTR_WIDTH-1:0] hit_data,
  input  logic                   fill_en,
  input  logic [31:2]            fill_addr,
  input  logic [INSTR_WIDTH-1:0] fill_data
);

  localparam int LINES     = 1 << INDEX_WIDTH;
  localparam int TAG_WIDTH = 30 - INDEX_WIDTH;

  logic [LINES-1:0]       valid_q;
  logic [TAG_WIDTH-1:0]   tag_q  [LINES];
  logic [INSTR_WIDTH-1:0] data_q [LINES];

  logic [INDEX_WIDTH-1:0] lookup_idx;
  logic [INDEX_WIDTH-1:0] fill_idx;

  assign lookup_idx = lookup_addr[INDEX_WIDTH+1:2];
  assign fill_idx   = fill_addr[INDEX_WIDTH+1:2];
  assign hit        = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_addr[31:INDEX_WIDTH+2]);
  assign hit_data   = data_q[lookup_idx];

  // Valid bits are the only cache state that needs clearing on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag and data storage written on every fill; contents are don't-care until valid.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= fill_addr[31:INDEX_WIDTH+2];
      data_q[fill_idx] <= fill_data;
    end
  end

endmodule

// File: rtl/instr_fetcher.sv
// Blocking instruction fetcher: owns the PC, fetches one word at a time, presents it to the Decoder.
// Latency: miss = memory latency + 1 cycle; optional I-cache (macro ICACHE_EN) presents a hit on the next edge.
// Backpressure: holds the presented word until dec_accept; no new fetch until the Decoder returns predict_pc.
module instr_fetcher
  import instr_fetcher_pkg::*;
#(
  parameter logic [31:0] RESET_PC           = 32'h0,
  parameter int          ICACHE_INDEX_WIDTH = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  input  logic [31:0] clear_pc,
  input  logic        dec_accept,
  input  logic        instr_issued,
  input  logic [31:0] predict_pc,
  output logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_addr_out,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_data
);

  fetch_state_t state;
  logic [31:0]  pc;

  logic                   cache_hit;
  logic [INSTR_WIDTH-1:0] cache_data;

`ifdef ICACHE_EN
  logic cache_fill;

  // Every word returned to a live request is cached; drained data never reaches here.
  assign cache_fill = rdy && (state == FETCH_WAIT_MEM) && mem_ready;

  instr_fetcher_icache #(
    .INDEX_WIDTH(ICACHE_INDEX_WIDTH)
  ) u_icache (
    .clk        (clk),
    .rst        (rst),
    .lookup_addr(pc[31:2]),
    .hit        (cache_hit),
    .hit_data   (cache_data),
    .fill_en    (cache_fill),
    .fill_addr  (mem_addr[31:2]),
    .fill_data  (mem_data)
  );
`else
  assign cache_hit  = 1'b0;
  assign cache_data = '0;
`endif

  // Fetch FSM; clear overrides every state and keeps an outstanding request alive in DRAIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= FETCH_IDLE;
      pc             <= RESET_PC;
      mem_req        <= 1'b0;
      mem_addr       <= '0;
      instr_ready    <= 1'b0;
      instr_out      <= '0;
      instr_addr_out <= '0;
    end else if (rdy) begin
      if (clear) begin
        pc          <= clear_pc;
        instr_ready <= 1'b0;
        if (mem_req && !mem_ready) begin
          state <= FETCH_DRAIN;
        end else begin
          state   <= FETCH_IDLE;
          mem_req <= 1'b0;
        end
      end else begin
        unique case (state)
          FETCH_IDLE: begin
            if (cache_hit) begin
              instr_ready    <= 1'b1;
              instr_out      <= cache_data;
              instr_addr_out <= pc;
              state          <= FETCH_HOLD;
            end else begin
              mem_req  <= 1'b1;
              mem_addr <= word_align(pc);
              state    <= FETCH_WAIT_MEM;
            end
          end
          FETCH_WAIT_MEM: begin
            if (mem_ready) begin
              mem_req        <= 1'b0;
              instr_ready    <= 1'b1;
              instr_out      <= mem_data;
              instr_addr_out <= pc;
              state          <= FETCH_HOLD;
            end
          end
          FETCH_HOLD: begin
            if (instr_ready && dec_accept) begin
              instr_ready <= 1'b0;
              state       <= FETCH_WAIT_PC;
            end
          end
          FETCH_WAIT_PC: begin
            if (instr_issued) begin
              pc    <= predict_pc;
              state <= FETCH_IDLE;
            end
          end
          FETCH_DRAIN: begin
            if (mem_ready) begin
              mem_req <= 1'b0;
              state   <= FETCH_IDLE;
            end
          end
          default: state <= FETCH_IDLE;
        endcase
      end
    end
  end

endmodule
